// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM sequence streamer.
package lstm_pkg;

  localparam int LSTM_DATA_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, WAIT} streamer_state_t;

endpackage

// File: rtl/lstm_sample_fifo.sv
// Synchronous FIFO for {last, y} samples; head is zero while empty.
module lstm_sample_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/lstm_sequence_streamer.sv
// Streams a sequence of x samples into lstm_layers and buffers y results for a valid/ready sink.
module lstm_sequence_streamer
  import lstm_pkg::*;
#(
  parameter int WIDTH         = LSTM_DATA_WIDTH,
  parameter int LAYERS        = 4,
  parameter int SEQ_LEN_WIDTH = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEQ_LEN_WIDTH-1:0]  cfg_seq_len,
  input  logic                      cfg_start,
  output logic                      busy,
  output logic                      done,
  output logic                      err_unexpected,
  input  logic [WIDTH-1:0]          s_x_data,
  input  logic                      s_x_valid,
  output logic                      s_x_ready,
  output logic [WIDTH-1:0]          lstm_x_in,
  output logic                      lstm_x_in_valid,
  output logic [LAYERS*WIDTH-1:0]   lstm_h_in,
  output logic [LAYERS-1:0]         lstm_h_in_valid,
  output logic [LAYERS*WIDTH-1:0]   lstm_C_in,
  output logic [LAYERS-1:0]         lstm_C_in_valid,
  input  logic                      lstm_ready,
  input  logic [WIDTH-1:0]          lstm_y_out,
  input  logic                      lstm_valid,
  output logic [WIDTH-1:0]          m_y_data,
  output logic                      m_y_last,
  output logic                      m_y_valid,
  input  logic                      m_y_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  streamer_state_t          state;
  logic [SEQ_LEN_WIDTH-1:0] len;
  logic [SEQ_LEN_WIDTH-1:0] out_cnt;
  logic [CW-1:0]            fifo_count;
  logic [WIDTH:0]           head;
  logic                     push;
  logic                     pop;
  logic                     last;

  assign last      = (out_cnt == len - 1'b1);
  assign push      = (state == WAIT) && lstm_valid;
  assign pop       = m_y_valid && m_y_ready;
  assign busy      = (state != IDLE);
  assign m_y_valid = (fifo_count != '0);
  assign {m_y_last, m_y_data} = head;
  assign lstm_h_in = '0;
  assign lstm_C_in = '0;

  // Only one x is ever in flight, so a free slot at accept time guarantees room for its y.
  assign s_x_ready = (state == FEED) && lstm_ready && (fifo_count < CW'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      len             <= '0;
      out_cnt         <= '0;
      done            <= 1'b0;
      err_unexpected  <= 1'b0;
      lstm_x_in       <= '0;
      lstm_x_in_valid <= 1'b0;
      lstm_h_in_valid <= '0;
      lstm_C_in_valid <= '0;
    end else begin
      done            <= 1'b0;
      lstm_x_in_valid <= 1'b0;
      lstm_h_in_valid <= '0;
      lstm_C_in_valid <= '0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            err_unexpected <= 1'b0;
            if (cfg_seq_len == '0) begin
              done <= 1'b1;
            end else begin
              len             <= cfg_seq_len;
              out_cnt         <= '0;
              lstm_h_in_valid <= '1;
              lstm_C_in_valid <= '1;
              state           <= CLEAR;
            end
          end
        end
        CLEAR: state <= FEED;
        FEED: begin
          if (s_x_valid && s_x_ready) begin
            lstm_x_in       <= s_x_data;
            lstm_x_in_valid <= 1'b1;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (lstm_valid) begin
            out_cnt <= out_cnt + 1'b1;
            if (last) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= FEED;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A stray result outside WAIT flags an error even on the cycle a start is accepted.
      if (lstm_valid && state != WAIT) err_unexpected <= 1'b1;
    end
  end

  lstm_sample_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({last, lstm_y_out}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

endmodule
